// File: rtl/dp_ram_arb.sv
// Round-robin front end for a single-clock dual-port RAM: one write and one
// read grant per cycle, same-address reads deferred behind the write.

module dp_ram_arb_rr #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic          o_vld,
  output logic [IW-1:0] o_idx,
  output logic [IW-1:0] o_nxt
);
  logic [IW-1:0] w_cand;

  // Walk from the farthest slot back to i_ptr so the nearest request wins.
  always_comb begin
    o_vld  = 1'b0;
    o_idx  = '0;
    w_cand = '0;
    for (int k = N-1; k >= 0; k--) begin
      w_cand = IW'((int'(i_ptr) + k) % N);
      if (i_req[w_cand]) begin
        o_vld = 1'b1;
        o_idx = w_cand;
      end
    end
    o_nxt = (int'(o_idx) == N-1) ? '0 : o_idx + 1'b1;
  end
endmodule

module dp_ram_arb #(
  parameter int RAM_WIDTH  = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int N_REQ      = 4,
  parameter int ID_W       = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_REQ-1:0]            wr_req,
  input  logic [N_REQ*ADDR_WIDTH-1:0] wr_addr,
  input  logic [N_REQ*RAM_WIDTH-1:0]  wr_data,
  output logic [N_REQ-1:0]            wr_gnt,
  input  logic [N_REQ-1:0]            rd_req,
  input  logic [N_REQ*ADDR_WIDTH-1:0] rd_addr,
  output logic [N_REQ-1:0]            rd_gnt,
  output logic                        rsp_valid,
  output logic [ID_W-1:0]             rsp_id,
  output logic [RAM_WIDTH-1:0]        rsp_data,
  output logic                        ram_write_allow,
  output logic [ADDR_WIDTH-1:0]       ram_write_addr,
  output logic [RAM_WIDTH-1:0]        ram_write_data,
  output logic                        ram_read_allow,
  output logic [ADDR_WIDTH-1:0]       ram_read_addr,
  input  logic [RAM_WIDTH-1:0]        ram_read_data
);
  logic [N_REQ-1:0][ADDR_WIDTH-1:0] w_wr_addr, w_rd_addr;
  logic [N_REQ-1:0][RAM_WIDTH-1:0]  w_wr_data;
  logic [ID_W-1:0] r_wr_ptr, r_rd_ptr, r_rsp_id;
  logic            r_rsp_valid;
  logic            w_wr_vld, w_rd_vld, w_coll, w_rd_go;
  logic [ID_W-1:0] w_wr_idx, w_rd_idx, w_wr_nxt, w_rd_nxt;

  assign w_wr_addr = wr_addr;
  assign w_rd_addr = rd_addr;
  assign w_wr_data = wr_data;

  dp_ram_arb_rr #(.N(N_REQ), .IW(ID_W)) u_wr_rr (
    .i_req (wr_req),
    .i_ptr (r_wr_ptr),
    .o_vld (w_wr_vld),
    .o_idx (w_wr_idx),
    .o_nxt (w_wr_nxt)
  );

  dp_ram_arb_rr #(.N(N_REQ), .IW(ID_W)) u_rd_rr (
    .i_req (rd_req),
    .i_ptr (r_rd_ptr),
    .o_vld (w_rd_vld),
    .o_idx (w_rd_idx),
    .o_nxt (w_rd_nxt)
  );

  // A read that hits this cycle's write address would see old data; hold it
  // (and the read pointer) one cycle so it re-arbitrates after the write lands.
  assign w_coll  = w_wr_vld & w_rd_vld & (w_rd_addr[w_rd_idx] == w_wr_addr[w_wr_idx]);
  assign w_rd_go = w_rd_vld & ~w_coll;

  always_comb begin
    wr_gnt = '0;
    rd_gnt = '0;
    if (w_wr_vld) wr_gnt[w_wr_idx] = 1'b1;
    if (w_rd_go)  rd_gnt[w_rd_idx] = 1'b1;
  end

  assign ram_write_allow = w_wr_vld;
  assign ram_write_addr  = w_wr_vld ? w_wr_addr[w_wr_idx] : '0;
  assign ram_write_data  = w_wr_vld ? w_wr_data[w_wr_idx] : '0;
  assign ram_read_allow  = w_rd_go;
  assign ram_read_addr   = w_rd_go ? w_rd_addr[w_rd_idx] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
    end else begin
      if (w_wr_vld) r_wr_ptr <= w_wr_nxt;
      if (w_rd_go) begin
        r_rd_ptr <= w_rd_nxt;
        r_rsp_id <= w_rd_idx;
      end
      r_rsp_valid <= w_rd_go;
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_data  = ram_read_data;
endmodule

// File: tb/tb_dp_ram_arb.sv
// Directed bench for dp_ram_arb with a behavioural RAM; read responses are
// scoreboarded by a negedge monitor against hand-computed expectations.

module tb_dp_ram_arb;
  logic             clk, rst_n;
  logic [3:0]       wr_req, rd_req, wr_gnt, rd_gnt;
  logic [3:0][3:0]  wr_a, rd_a;
  logic [3:0][7:0]  wr_d;
  logic             rsp_valid;
  logic [1:0]       rsp_id;
  logic [7:0]       rsp_data;
  logic             ram_write_allow, ram_read_allow;
  logic [3:0]       ram_write_addr, ram_read_addr;
  logic [7:0]       ram_write_data, ram_read_data;
  logic [7:0]       mem [16];

  int n_chk = 0;
  int n_fail = 0;
  logic [9:0] sb [$];  // {id, data}

  dp_ram_arb dut (
    .clk(clk), .rst_n(rst_n),
    .wr_req(wr_req), .wr_addr(wr_a), .wr_data(wr_d), .wr_gnt(wr_gnt),
    .rd_req(rd_req), .rd_addr(rd_a), .rd_gnt(rd_gnt),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .ram_write_allow(ram_write_allow), .ram_write_addr(ram_write_addr),
    .ram_write_data(ram_write_data), .ram_read_allow(ram_read_allow),
    .ram_read_addr(ram_read_addr), .ram_read_data(ram_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_write_allow) mem[ram_write_addr] <= ram_write_data;
    if (ram_read_allow)  ram_read_data <= mem[ram_read_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor
  initial begin
    logic [9:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && rsp_valid) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_rsp: got id %0d data %0h expected no response", rsp_id, rsp_data);
        end else begin
          e = sb.pop_front();
          chk("rsp_id", {30'd0, rsp_id}, {30'd0, e[9:8]});
          chk("rsp_data", {24'd0, rsp_data}, {24'd0, e[7:0]});
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; wr_req = '0; rd_req = '0; wr_a = '0; rd_a = '0; wr_d = '0;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_wr_gnt", {28'd0, wr_gnt}, 32'd0);
    chk("rst_rd_gnt", {28'd0, rd_gnt}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_id", {30'd0, rsp_id}, 32'd0);
    chk("rst_wallow", {31'd0, ram_write_allow}, 32'd0);
    chk("rst_rallow", {31'd0, ram_read_allow}, 32'd0);

    // Write round-robin, all four requesting
    next_cycle();
    rst_n = 1'b1;
    wr_req = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      wr_a[i] = 4'(i);
      wr_d[i] = 8'hA0 + 8'(i);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rr_wr_gnt", {28'd0, wr_gnt}, 32'd1 << (i % 4));
      chk("rr_waddr", {28'd0, ram_write_addr}, 32'(i % 4));
      chk("rr_wdata", {24'd0, ram_write_data}, 32'hA0 + 32'(i % 4));
      next_cycle();
    end
    wr_req = '0;

    // Readback addr 2 (rd_ptr 0 -> requester 0)
    rd_req = 4'b0001; rd_a[0] = 4'd2;
    sb.push_back({2'd0, 8'hA2});
    @(negedge clk);
    chk("rb_rd_gnt", {28'd0, rd_gnt}, 32'b0001);
    next_cycle();
    rd_req = '0;

    // Preload addr5=5C, addr7=11 (wr_ptr 1 -> requester 0 wins both, ptr back to 1)
    wr_req = 4'b0001; wr_a[0] = 4'd5; wr_d[0] = 8'h5C;
    @(negedge clk);
    chk("pl_wr_gnt0", {28'd0, wr_gnt}, 32'b0001);
    next_cycle();
    wr_a[0] = 4'd7; wr_d[0] = 8'h11;
    @(negedge clk);
    chk("pl_wr_gnt1", {28'd0, wr_gnt}, 32'b0001);
    next_cycle();
    wr_req = '0;

    // Read latency and tag: requester 3 reads addr 5 (rd_ptr 1)
    rd_req = 4'b1000; rd_a[3] = 4'd5;
    sb.push_back({2'd3, 8'h5C});
    @(negedge clk);
    chk("lat_rd_gnt", {28'd0, rd_gnt}, 32'b1000);
    next_cycle();
    rd_req = '0;
    @(negedge clk);
    chk("lat_t1_valid", {31'd0, rsp_valid}, 32'd1);
    chk("lat_t1_id", {30'd0, rsp_id}, 32'd3);
    chk("lat_t1_data", {24'd0, rsp_data}, 32'h5C);
    next_cycle();
    @(negedge clk);
    chk("lat_t2_valid", {31'd0, rsp_valid}, 32'd0);
    next_cycle();

    // Collision: req1 writes addr7=3E, req2 reads addr7 (wr_ptr 1, rd_ptr 0)
    wr_req = 4'b0010; wr_a[1] = 4'd7; wr_d[1] = 8'h3E;
    rd_req = 4'b0100; rd_a[2] = 4'd7;
    @(negedge clk);
    chk("col_wr_gnt", {28'd0, wr_gnt}, 32'b0010);
    chk("col_rd_gnt_t", {28'd0, rd_gnt}, 32'd0);
    chk("col_rallow_t", {31'd0, ram_read_allow}, 32'd0);
    next_cycle();
    wr_req = '0;
    sb.push_back({2'd2, 8'h3E});
    @(negedge clk);
    chk("col_rd_gnt_t1", {28'd0, rd_gnt}, 32'b0100);
    chk("col_valid_t1", {31'd0, rsp_valid}, 32'd0);
    next_cycle();
    rd_req = '0;
    @(negedge clk);
    chk("col_valid_t2", {31'd0, rsp_valid}, 32'd1);
    chk("col_id_t2", {30'd0, rsp_id}, 32'd2);
    chk("col_data_t2", {24'd0, rsp_data}, 32'h3E);
    next_cycle();

    // Pointer wrap with skip: move wr_ptr 2 -> 3, then wr_req=0101
    wr_req = 4'b0100; wr_a[2] = 4'd9; wr_d[2] = 8'h99;
    @(negedge clk);
    chk("wrap_setup_gnt", {28'd0, wr_gnt}, 32'b0100);
    next_cycle();
    wr_req = 4'b0101; wr_a[0] = 4'd10; wr_d[0] = 8'h10; wr_a[2] = 4'd11; wr_d[2] = 8'h22;
    @(negedge clk);
    chk("wrap_gnt0", {28'd0, wr_gnt}, 32'b0001);
    next_cycle();
    @(negedge clk);
    chk("wrap_gnt2", {28'd0, wr_gnt}, 32'b0100);
    chk("wrap_waddr", {28'd0, ram_write_addr}, 32'd11);
    next_cycle();
    wr_req = '0;

    // Reset mid-read: rd_ptr 3 -> requester 1 granted, then reset before the edge
    rd_req = 4'b0010; rd_a[1] = 4'd1;
    @(negedge clk);
    chk("mid_rd_gnt", {28'd0, rd_gnt}, 32'b0010);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("mid_valid_rst", {31'd0, rsp_valid}, 32'd0);
    next_cycle();
    rst_n = 1'b1;
    rd_req = 4'b1111;
    for (int i = 0; i < 4; i++) rd_a[i] = 4'd2;
    sb.push_back({2'd0, 8'hA2});
    @(negedge clk);
    chk("mid_valid_rel", {31'd0, rsp_valid}, 32'd0);
    chk("mid_rdptr0_gnt", {28'd0, rd_gnt}, 32'b0001);
    next_cycle();
    rd_req = '0;

    repeat (3) next_cycle();
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
